// File: rtl/xdma_stream_packer.sv
// Splits each accepted IN_WIDTH packet into 512-bit beats (little-endian) and streams them via an FWFT FIFO
// as AXI-stream; beat 0 reaches the FIFO one cycle after acceptance, and a full FIFO stalls the split and the core clock.
module xdma_stream_packer_fifo #(
    parameter int WIDTH = 513,
    parameter int DEPTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head_dat
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign head_dat = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_dat;
    end
endmodule

module xdma_stream_packer #(
    parameter int IN_WIDTH   = 2048,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 host_enable,
    input  logic                 in_valid,
    input  logic [IN_WIDTH-1:0]  in_data,
    output logic                 core_clock_enable,
    output logic                 axi_tvalid,
    input  logic                 axi_tready,
    output logic [511:0]         axi_tdata,
    output logic                 axi_tlast,
    output logic [CNT_WIDTH-1:0] pkt_count,
    output logic [CNT_WIDTH-1:0] stall_cycles
);
    localparam int BEATS = IN_WIDTH / 512;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic {IDLE, SEND} state_t;

    state_t                state_q, state_d;
    logic [IN_WIDTH-1:0]   shift_q, shift_d;
    logic [BW-1:0]         beat_cnt_q, beat_cnt_d;
    logic                  cce_q, cce_d;
    logic [CNT_WIDTH-1:0]  pkt_count_q, pkt_count_d;
    logic [CNT_WIDTH-1:0]  stall_q, stall_d;

    logic                  accept, beat_last;
    logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [512:0]          fifo_head;

    assign accept    = in_valid && cce_q;
    assign beat_last = (beat_cnt_q == BW'(BEATS - 1));
    assign fifo_pop  = !fifo_empty && axi_tready;

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        beat_cnt_d  = beat_cnt_q;
        pkt_count_d = pkt_count_q;
        fifo_push   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    shift_d     = in_data;
                    beat_cnt_d  = '0;
                    state_d     = SEND;
                    pkt_count_d = pkt_count_q + CNT_WIDTH'(1);
                end
            end
            SEND: begin
                // Full is the pre-pop status, so a same-cycle pop never frees a slot for this push.
                if (!fifo_full) begin
                    fifo_push  = 1'b1;
                    shift_d    = shift_q >> 512;
                    beat_cnt_d = beat_cnt_q + BW'(1);
                    if (beat_last) state_d = IDLE;
                end
            end
        endcase
        cce_d   = (state_d == IDLE) && host_enable;
        stall_d = stall_q + {{(CNT_WIDTH-1){1'b0}}, ~cce_q};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            beat_cnt_q  <= '0;
            cce_q       <= 1'b0;
            pkt_count_q <= '0;
            stall_q     <= '0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            beat_cnt_q  <= beat_cnt_d;
            cce_q       <= cce_d;
            pkt_count_q <= pkt_count_d;
            stall_q     <= stall_d;
        end
    end

    xdma_stream_packer_fifo #(
        .WIDTH (513),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (fifo_push),
        .push_dat ({beat_last, shift_q[511:0]}),
        .pop      (fifo_pop),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head_dat (fifo_head)
    );

    assign core_clock_enable = cce_q;
    assign axi_tvalid        = !fifo_empty;
    assign axi_tdata         = fifo_head[511:0];
    assign axi_tlast         = fifo_head[512] && !fifo_empty;
    assign pkt_count         = pkt_count_q;
    assign stall_cycles      = stall_q;
endmodule

// File: tb/tb_xdma_stream_packer.sv
// Randomized bench for xdma_stream_packer against a per-cycle behavioural model
// (pending-beat count, queue-based FIFO contents, counters).
module tb_xdma_stream_packer;
    localparam int IN_WIDTH = 2048;
    localparam int BEATS    = IN_WIDTH / 512;
    localparam int DEPTH    = 16;
    localparam int CW       = 32;

    logic                clock = 1'b0;
    logic                reset;
    logic                host_enable, in_valid, axi_tready;
    logic [IN_WIDTH-1:0] in_data;
    logic                core_clock_enable, axi_tvalid, axi_tlast;
    logic [511:0]        axi_tdata;
    logic [CW-1:0]       pkt_count, stall_cycles;

    xdma_stream_packer #(.IN_WIDTH(IN_WIDTH), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
        .clock(clock), .reset(reset), .host_enable(host_enable), .in_valid(in_valid),
        .in_data(in_data), .core_clock_enable(core_clock_enable), .axi_tvalid(axi_tvalid),
        .axi_tready(axi_tready), .axi_tdata(axi_tdata), .axi_tlast(axi_tlast),
        .pkt_count(pkt_count), .stall_cycles(stall_cycles)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    // Behavioural model
    int                  pend;
    int                  cyc = 0;
    logic                cce_m;
    logic [CW-1:0]       pkt_m, stall_m;
    logic [IN_WIDTH-1:0] cur_pkt;
    logic [512:0]        mq[$];
    logic [512:0]        rx[$];
    int                  rx_cyc[$];
    logic [IN_WIDTH-1:0] pkts[$];

    task automatic model_clear();
        pend = 0; mq.delete(); cce_m = 1'b0; pkt_m = '0; stall_m = '0;
    endtask

    // Records the handshake about to happen, advances the model, then crosses one edge.
    task automatic step();
        bit full_m, pop_m, acc_m, push_m;
        int idx;
        logic [512:0] junk;
        if (reset) begin
            model_clear();
        end else begin
            if (axi_tvalid && axi_tready) begin
                rx.push_back({axi_tlast, axi_tdata});
                rx_cyc.push_back(cyc);
            end
            full_m = (mq.size() == DEPTH);
            pop_m  = (mq.size() != 0) && axi_tready;
            acc_m  = (pend == 0) && in_valid && cce_m;
            push_m = (pend != 0) && !full_m;
            if (!cce_m) stall_m = stall_m + 1;
            if (pop_m) junk = mq.pop_front();
            if (push_m) begin
                idx = BEATS - pend;
                mq.push_back({(idx == BEATS-1), cur_pkt[idx*512 +: 512]});
                pend = pend - 1;
            end
            if (acc_m) begin
                cur_pkt = in_data; pend = BEATS; pkt_m = pkt_m + 1;
            end
            cce_m = (pend == 0) && host_enable;
        end
        cyc++;
        @(posedge clock); #1;
    endtask

    function automatic logic [IN_WIDTH-1:0] rand_pkt();
        logic [IN_WIDTH-1:0] p;
        for (int i = 0; i < IN_WIDTH/32; i++) p[i*32 +: 32] = $urandom;
        return p;
    endfunction

    task automatic send_pkt(input logic [IN_WIDTH-1:0] d, output bit ok);
        ok = 0;
        for (int i = 0; i < 80 && !ok; i++) begin
            if (core_clock_enable) begin
                in_valid = 1'b1; in_data = d;
                step();
                in_valid = 1'b0;
                pkts.push_back(d);
                ok = 1;
            end else begin
                step();
            end
        end
    endtask

    task automatic drain(output bit ok);
        ok = 0;
        axi_tready = 1'b1;
        for (int i = 0; i < 300 && !ok; i++) begin
            if (!axi_tvalid && pend == 0) ok = 1;
            else step();
        end
    endtask

    task automatic clear_logs();
        rx.delete(); rx_cyc.delete(); pkts.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1; host_enable = 1'b1; in_valid = 1'b0; axi_tready = 1'b1; in_data = '0;
        model_clear();
        #2;
        tests++;
        if (axi_tvalid !== 1'b0 || axi_tlast !== 1'b0 || core_clock_enable !== 1'b0) begin
            fails++; $display("FAIL reset_outputs: tvalid=%b tlast=%b cce=%b expected 0 0 0", axi_tvalid, axi_tlast, core_clock_enable);
        end
        tests++;
        if (pkt_count !== '0 || stall_cycles !== '0) begin
            fails++; $display("FAIL reset_counters: pkt=%0d stall=%0d expected 0 0", pkt_count, stall_cycles);
        end
        @(posedge clock); #1; step();
        reset = 1'b0;
        step();
        tests++;
        if (core_clock_enable !== 1'b1 || stall_cycles !== 32'd1) begin
            fails++; $display("FAIL reset_release: cce=%b stall=%0d expected 1 1", core_clock_enable, stall_cycles);
        end
    endtask

    task automatic test_basic();
        logic [IN_WIDTH-1:0] d;
        logic [31:0] w;
        logic [512:0] e;
        bit ok;
        clear_logs(); host_enable = 1'b1; axi_tready = 1'b1;
        for (int k = 0; k < BEATS; k++) begin
            w = 32'h1000_0000 + 32'(k);
            d[k*512 +: 512] = {16{w}};
        end
        send_pkt(d, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL basic_send: timeout got 0 expected 1"); end
        for (int i = 1; i <= BEATS + 1; i++) begin
            tests++;
            if (core_clock_enable !== (i == BEATS + 1)) begin
                fails++; $display("FAIL basic_cce cycle %0d: got %b expected %b", i, core_clock_enable, (i == BEATS + 1));
            end
            if (i <= BEATS) step();
        end
        drain(ok);
        tests++;
        if (!ok || rx.size() != BEATS) begin
            fails++; $display("FAIL basic_count: got %0d beats expected %0d", rx.size(), BEATS);
        end else begin
            for (int k = 0; k < BEATS; k++) begin
                w = 32'h1000_0000 + 32'(k);
                e = {(k == BEATS-1), {16{w}}};
                tests++;
                if (rx[k] !== e || rx_cyc[k] != rx_cyc[0] + k) begin
                    fails++; $display("FAIL basic_beat%0d: got %h at +%0d expected %h at +%0d", k, rx[k], rx_cyc[k]-rx_cyc[0], e, k);
                end
            end
        end
        tests++;
        if (pkt_count !== 32'd1 || stall_cycles !== stall_m) begin
            fails++; $display("FAIL basic_counters: pkt=%0d stall=%0d expected 1 %0d", pkt_count, stall_cycles, stall_m);
        end
    endtask

    task automatic fill_five(output bit ok);
        bit ok1;
        ok = 1;
        axi_tready = 1'b0; host_enable = 1'b1;
        for (int p = 0; p < 5; p++) begin
            send_pkt(rand_pkt(), ok1);
            if (!ok1) ok = 0;
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        logic [512:0] e;
        clear_logs();
        fill_five(ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL bp_fill: timeout got 0 expected 1"); end
        for (int i = 0; i < 6; i++) begin
            step();
            tests++;
            if (core_clock_enable !== 1'b0 || axi_tvalid !== 1'b1 || core_clock_enable !== cce_m) begin
                fails++; $display("FAIL bp_stall cycle %0d: cce=%b tvalid=%b expected 0 1", i, core_clock_enable, axi_tvalid);
            end
        end
        drain(ok);
        tests++;
        if (!ok || rx.size() != 5*BEATS) begin
            fails++; $display("FAIL bp_count: got %0d beats expected %0d", rx.size(), 5*BEATS);
        end else begin
            for (int j = 0; j < 5*BEATS; j++) begin
                e = {((j % 4) == 3), pkts[j/BEATS][(j%BEATS)*512 +: 512]};
                tests++;
                if (rx[j] !== e) begin
                    fails++; $display("FAIL bp_beat%0d: got %h expected %h", j, rx[j], e);
                end
            end
        end
        tests++;
        if (pkt_count !== pkt_m || stall_cycles !== stall_m) begin
            fails++; $display("FAIL bp_counters: pkt=%0d stall=%0d expected %0d %0d", pkt_count, stall_cycles, pkt_m, stall_m);
        end
    endtask

    task automatic test_host_gating();
        bit ok;
        int lowcnt;
        logic [CW-1:0] stall_base, pkt_base;
        logic [512:0] e;
        clear_logs(); host_enable = 1'b1; axi_tready = 1'b1;
        drain(ok);
        stall_base = stall_m; pkt_base = pkt_m; lowcnt = 0;
        if (!core_clock_enable) lowcnt++;
        send_pkt(rand_pkt(), ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL host_send: timeout got 0 expected 1"); end
        if (!core_clock_enable) lowcnt++;
        step();
        host_enable = 1'b0; in_valid = 1'b1; in_data = rand_pkt();
        for (int i = 0; i < 8; i++) begin
            if (!core_clock_enable) lowcnt++;
            step();
            tests++;
            if (core_clock_enable !== 1'b0) begin
                fails++; $display("FAIL host_gated cycle %0d: cce=%b expected 0", i, core_clock_enable);
            end
        end
        tests++;
        if (pkt_count !== pkt_base + 1) begin
            fails++; $display("FAIL host_ignore: pkt=%0d expected %0d", pkt_count, pkt_base + 1);
        end
        host_enable = 1'b1; in_valid = 1'b0;
        if (!core_clock_enable) lowcnt++;
        step();
        tests++;
        if (core_clock_enable !== 1'b1) begin
            fails++; $display("FAIL host_restore: cce=%b expected 1", core_clock_enable);
        end
        tests++;
        if (stall_cycles !== stall_base + CW'(lowcnt)) begin
            fails++; $display("FAIL host_stall: got %0d expected %0d", stall_cycles, stall_base + CW'(lowcnt));
        end
        drain(ok);
        tests++;
        if (!ok || rx.size() != BEATS) begin
            fails++; $display("FAIL host_count: got %0d beats expected %0d", rx.size(), BEATS);
        end else begin
            for (int k = 0; k < BEATS; k++) begin
                e = {(k == BEATS-1), pkts[0][k*512 +: 512]};
                tests++;
                if (rx[k] !== e) begin fails++; $display("FAIL host_beat%0d: got %h expected %h", k, rx[k], e); end
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        clear_logs(); host_enable = 1'b1; axi_tready = 1'b0;
        send_pkt(rand_pkt(), ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL rstmid_send: timeout got 0 expected 1"); end
        step(); step();
        reset = 1'b1;
        #1;
        tests++;
        if (axi_tvalid !== 1'b0 || axi_tlast !== 1'b0 || core_clock_enable !== 1'b0 ||
            pkt_count !== '0 || stall_cycles !== '0) begin
            fails++; $display("FAIL rstmid_immediate: tvalid=%b tlast=%b cce=%b pkt=%0d stall=%0d expected all 0",
                              axi_tvalid, axi_tlast, core_clock_enable, pkt_count, stall_cycles);
        end
        step();
        reset = 1'b0; axi_tready = 1'b1;
        step();
        tests++;
        if (core_clock_enable !== 1'b1 || stall_cycles !== 32'd1) begin
            fails++; $display("FAIL rstmid_release: cce=%b stall=%0d expected 1 1", core_clock_enable, stall_cycles);
        end
        for (int i = 0; i < 6; i++) begin
            step();
            tests++;
            if (axi_tvalid !== 1'b0) begin
                fails++; $display("FAIL rstmid_stale cycle %0d: tvalid=%b expected 0", i, axi_tvalid);
            end
        end
        tests++;
        if (rx.size() != 0) begin fails++; $display("FAIL rstmid_rx: got %0d beats expected 0", rx.size()); end
    endtask

    task automatic test_tready_toggle();
        int sent;
        bit hold;
        logic [512:0] hv, e;
        clear_logs(); host_enable = 1'b1; sent = 0;
        for (int c = 0; c < 400 && !(sent == 3 && rx.size() == 3*BEATS); c++) begin
            axi_tready = ((c % 2) == 1);
            in_valid = core_clock_enable && (sent < 3);
            if (in_valid) begin
                in_data = rand_pkt(); pkts.push_back(in_data); sent++;
            end
            if (axi_tvalid || mq.size() != 0) begin
                tests++;
                if (mq.size() == 0 || axi_tvalid !== 1'b1 || {axi_tlast, axi_tdata} !== mq[0]) begin
                    fails++; $display("FAIL toggle_head cycle %0d: tvalid=%b model_occ=%0d", c, axi_tvalid, mq.size());
                end
            end
            hold = axi_tvalid && !axi_tready;
            hv = {axi_tlast, axi_tdata};
            step();
            in_valid = 1'b0;
            if (hold) begin
                tests++;
                if (axi_tvalid !== 1'b1 || {axi_tlast, axi_tdata} !== hv) begin
                    fails++; $display("FAIL toggle_stable cycle %0d: got %b/%h expected 1/%h", c, axi_tvalid, {axi_tlast, axi_tdata}, hv);
                end
            end
            tests++;
            if (core_clock_enable !== cce_m) begin
                fails++; $display("FAIL toggle_cce cycle %0d: got %b expected %b", c, core_clock_enable, cce_m);
            end
        end
        tests++;
        if (rx.size() != 3*BEATS) begin
            fails++; $display("FAIL toggle_count: got %0d beats expected %0d", rx.size(), 3*BEATS);
        end else begin
            for (int j = 0; j < 3*BEATS; j++) begin
                e = {((j % BEATS) == BEATS-1), pkts[j/BEATS][(j%BEATS)*512 +: 512]};
                tests++;
                if (rx[j] !== e) begin fails++; $display("FAIL toggle_beat%0d: got %h expected %h", j, rx[j], e); end
            end
        end
    endtask

    task automatic test_simultaneous();
        bit ok;
        logic [512:0] e;
        clear_logs();
        fill_five(ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL simul_fill: timeout got 0 expected 1"); end
        step(); step(); step();
        axi_tready = 1'b1;
        step();
        tests++;
        if (core_clock_enable !== 1'b0 || axi_tvalid !== 1'b1) begin
            fails++; $display("FAIL simul_blocked: cce=%b tvalid=%b expected 0 1", core_clock_enable, axi_tvalid);
        end
        for (int i = 1; i <= BEATS; i++) begin
            step();
            tests++;
            if (axi_tvalid !== 1'b1 || core_clock_enable !== (i == BEATS)) begin
                fails++; $display("FAIL simul_cycle%0d: tvalid=%b cce=%b expected 1 %b", i, axi_tvalid, core_clock_enable, (i == BEATS));
            end
        end
        drain(ok);
        tests++;
        if (!ok || rx.size() != 5*BEATS) begin
            fails++; $display("FAIL simul_count: got %0d beats expected %0d", rx.size(), 5*BEATS);
        end else begin
            for (int j = 0; j < 5*BEATS; j++) begin
                e = {((j % BEATS) == BEATS-1), pkts[j/BEATS][(j%BEATS)*512 +: 512]};
                tests++;
                if (rx[j] !== e) begin fails++; $display("FAIL simul_beat%0d: got %h expected %h", j, rx[j], e); end
            end
        end
        tests++;
        if (pkt_count !== pkt_m || stall_cycles !== stall_m) begin
            fails++; $display("FAIL simul_counters: pkt=%0d stall=%0d expected %0d %0d", pkt_count, stall_cycles, pkt_m, stall_m);
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_host_gating();
        test_reset_mid();
        test_tready_toggle();
        test_simultaneous();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
